rocket_move: RTL and testbench
==============================

Name: rocket_move

Overview:
- Rocket motion controller; sits directly upstream of the rocket bitmap stage.
- Launches one rocket from the tank muzzle on a fire-key press and advances it once per video frame along the latched direction.
- Retires the rocket on collision or screen exit, then enforces a reload cooldown.
- Drives rocket topLeft to the square-object stage, plus last_direction and rocket_enable to the bitmap stage.

Parameters:
- SPEED, 4, pixels moved per startOfFrame pulse.
- TANK_SIZE, 32, tank square side in pixels.
- ROCKET_SIZE, 8, rocket square side in pixels.
- SCREEN_W, 640, visible width in pixels.
- SCREEN_H, 480, visible height in pixels.
- COOLDOWN_FRAMES, 30, frames between rocket retirement and the next allowed launch.
- EXPLODE_FRAMES, 8, explosion hold time in frames; used only with the optional feature.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- startOfFrame  in  1  one-cycle pulse per frame.
- fire_key  in  1  level from keypad.
- tank_topLeftX  in  11  tank X position.
- tank_topLeftY  in  11  tank Y position.
- tank_direction  in  2  direction encoding: 0 up, 1 right, 2 down, 3 left.
- collision  in  1  rocket pixel overlaps wall or tank.
- topLeftX  out  11  rocket X position.
- topLeftY  out  11  rocket Y position.
- last_direction  out  2  latched flight direction.
- rocket_enable  out  1  rocket visible/active.
- explode  out  1  explosion phase active.

Behaviour:
- Reset: topLeftX=0, topLeftY=0, last_direction=0, rocket_enable=0, explode=0, fire_prev=0, cooldown counter=0, state=IDLE.
- States:
  - IDLE, FLYING, COOLDOWN, plus EXPLODE when the optional feature is compiled in.
  - Registered 2-bit state; all outputs are registered.
- Fire detection: rising edge only (fire_key=1 && fire_prev=0). fire_prev updates every cycle in every state.
- Spawn arithmetic:
  - Computed in signed 12-bit; C = (TANK_SIZE-ROCKET_SIZE)/2.
  - up: X=tx+C, Y=ty-ROCKET_SIZE.
  - right: X=tx+TANK_SIZE, Y=ty+C.
  - down: X=tx+C, Y=ty+TANK_SIZE.
  - left: X=tx-ROCKET_SIZE, Y=ty+C.
- In-bounds rule: 0 <= X <= SCREEN_W-ROCKET_SIZE and 0 <= Y <= SCREEN_H-ROCKET_SIZE.
- IDLE:
  - Fire edge at cycle n with in-bounds spawn: at the next edge, load topLeft and last_direction=tank_direction, set rocket_enable=1, go to FLYING. Latency is 1 cycle.
  - Fire edge with out-of-bounds spawn: nothing is loaded, rocket_enable stays 0, go to COOLDOWN.
- FLYING, checked in this priority:
  - collision=1 (any cycle, including a cycle coinciding with startOfFrame): rocket_enable<=0, no move, go to COOLDOWN. With the optional feature, go to EXPLODE instead.
  - startOfFrame with next position (current ± SPEED on the axis of last_direction, signed 12-bit) in bounds: update topLeft.
  - startOfFrame with next position out of bounds: rocket_enable<=0, position held, go to COOLDOWN.
  - Tank direction or position changes during flight have no effect on the rocket.
  - Fire edges are ignored.
- COOLDOWN:
  - Counter loads 0 on entry and increments on each startOfFrame.
  - On the pulse that brings it to COOLDOWN_FRAMES, go to IDLE.
  - Fire is ignored throughout. A key held across the end of cooldown does not fire; a new rising edge is required.
- Only one rocket exists at any time.
- Reset asserted mid-flight: next edge returns everything to reset values; rocket_enable drops that cycle.

Optional Feature:
- Macro: ROCKET_EXPLOSION_EN.
- Defined:
  - Collision in FLYING goes to EXPLODE.
  - In EXPLODE, rocket_enable=1 and explode=1, and position is frozen.
  - After EXPLODE_FRAMES startOfFrame pulses, rocket_enable=0, explode=0, go to COOLDOWN.
  - Screen exit still goes directly to COOLDOWN.
- Undefined: EXPLODE state is absent, explode is tied 0, and collision goes directly to COOLDOWN.

Decomposition:
- Package rocket_pkg holds:
  - dir_t enum (UP=0, RIGHT=1, DOWN=2, LEFT=3).
  - rocket_state_t enum.
  - ROCKET_SIZE, TANK_SIZE, SCREEN_W and SCREEN_H constants.
  - The in-bounds check function.
- Sub-module: frame_counter. Counts startOfFrame pulses, with clear, enable and a terminal-count compare. Used for both the cooldown and explosion timers.

Test Plan:
- Spawn up: tank (100,200), dir 0, fire edge → next cycle topLeft=(112,192), last_direction=0, rocket_enable=1. After 3 frames, topLeftY=180.
- Spawn right: tank (100,200), dir 1 → topLeft=(132,212). Tank then turns to dir 2; after 2 frames the rocket is at X=140, Y=212 and last_direction stays 1.
- Edge exit: rocket flying up at Y=6 → after 1 frame Y=2; on the next frame rocket_enable=0 and state=COOLDOWN. A fire edge 5 frames later is ignored. After 30 frames, a held key does not fire and a new edge launches.
- Blocked spawn: tank (100,4), dir 0 → spawn Y=-4, rocket_enable stays 0, COOLDOWN entered.
- Collision coinciding with startOfFrame: position unchanged and rocket_enable=0. With ROCKET_EXPLOSION_EN, explode=1 for exactly 8 frames, then 0.
- Reset mid-flight at (300,100) → next cycle all outputs 0 and state IDLE; fire works immediately after reset.

Source files
------------

// File: rtl/rocket_pkg.sv
// Shared types, screen/object geometry and the on-screen test for rocket_move.
// Optional macro ROCKET_EXPLOSION_EN adds the S_EXPLODE state.
package rocket_pkg;

   typedef enum logic [1:0] {
      UP    = 2'd0,
      RIGHT = 2'd1,
      DOWN  = 2'd2,
      LEFT  = 2'd3
   } dir_t;

`ifdef ROCKET_EXPLOSION_EN
   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_FLYING   = 2'd1,
      S_COOLDOWN = 2'd2,
      S_EXPLODE  = 2'd3
   } rocket_state_t;
`else
   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_FLYING   = 2'd1,
      S_COOLDOWN = 2'd2
   } rocket_state_t;
`endif

   localparam int ROCKET_SIZE = 8;
   localparam int TANK_SIZE   = 32;
   localparam int SCREEN_W    = 640;
   localparam int SCREEN_H    = 480;

   // True when a rocket whose top-left corner is (x,y) lies fully on screen.
   function automatic logic in_bounds(input logic signed [11:0] x,
                                      input logic signed [11:0] y,
                                      input int max_x,
                                      input int max_y);
      return (int'(x) >= 0) && (int'(x) <= max_x) &&
             (int'(y) >= 0) && (int'(y) <= max_y);
   endfunction

endpackage

// File: rtl/rocket_move_frame_counter.sv
// Counts startOfFrame pulses; hit flags the pulse that reaches the terminal count.
module frame_counter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             enable,
   input  logic [WIDTH-1:0] terminal,
   output logic [WIDTH-1:0] count,
   output logic             hit
);

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   logic [WIDTH-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clear)
         count_d = '0;
      else if (enable)
         count_d = count_q + ONE;
   end

   always_ff @(posedge clk) begin
      if (reset)
         count_q <= '0;
      else
         count_q <= count_d;
   end

   assign count = count_q;
   assign hit   = enable && ((count_q + ONE) == terminal);

endmodule

// File: rtl/rocket_move.sv
// Rocket motion controller: launch on fire edge, per-frame advance, retire, cooldown.
// Optional macro ROCKET_EXPLOSION_EN holds an explosion phase after a collision.
module rocket_move #(
   parameter int SPEED           = 4,
   parameter int TANK_SIZE       = rocket_pkg::TANK_SIZE,
   parameter int ROCKET_SIZE     = rocket_pkg::ROCKET_SIZE,
   parameter int SCREEN_W        = rocket_pkg::SCREEN_W,
   parameter int SCREEN_H        = rocket_pkg::SCREEN_H,
   parameter int COOLDOWN_FRAMES = 30,
   parameter int EXPLODE_FRAMES  = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        startOfFrame,
   input  logic        fire_key,
   input  logic [10:0] tank_topLeftX,
   input  logic [10:0] tank_topLeftY,
   input  logic [1:0]  tank_direction,
   input  logic        collision,
   output logic [10:0] topLeftX,
   output logic [10:0] topLeftY,
   output logic [1:0]  last_direction,
   output logic        rocket_enable,
   output logic        explode
);

   import rocket_pkg::*;

   localparam int CNT_W = 8;
   localparam logic signed [11:0] C_OFF = 12'((TANK_SIZE - ROCKET_SIZE) / 2);
   localparam logic signed [11:0] R_SZ  = 12'(ROCKET_SIZE);
   localparam logic signed [11:0] T_SZ  = 12'(TANK_SIZE);
   localparam logic signed [11:0] SPD   = 12'(SPEED);
   localparam int MAX_X = SCREEN_W - ROCKET_SIZE;
   localparam int MAX_Y = SCREEN_H - ROCKET_SIZE;

   rocket_state_t state_q, state_d;
   dir_t          dir_q, dir_d;
   logic [10:0]   x_q, x_d, y_q, y_d;
   logic          en_q, en_d;
   logic          fire_prev_q;
`ifdef ROCKET_EXPLOSION_EN
   logic          explode_q, explode_d;
`endif

   logic signed [11:0] tx_s, ty_s, cur_x, cur_y;
   logic signed [11:0] spawn_x, spawn_y, next_x, next_y;
   logic               fire_edge, tc_hit, tc_enable, tc_clear;
   logic [CNT_W-1:0]   tc_terminal, tc_count;

   assign tx_s      = $signed({1'b0, tank_topLeftX});
   assign ty_s      = $signed({1'b0, tank_topLeftY});
   assign cur_x     = $signed({1'b0, x_q});
   assign cur_y     = $signed({1'b0, y_q});
   assign fire_edge = fire_key && !fire_prev_q;

   always_comb begin
      spawn_x = tx_s + C_OFF;
      spawn_y = ty_s - R_SZ;
      case (dir_t'(tank_direction))
         UP:    begin spawn_x = tx_s + C_OFF; spawn_y = ty_s - R_SZ;  end
         RIGHT: begin spawn_x = tx_s + T_SZ;  spawn_y = ty_s + C_OFF; end
         DOWN:  begin spawn_x = tx_s + C_OFF; spawn_y = ty_s + T_SZ;  end
         LEFT:  begin spawn_x = tx_s - R_SZ;  spawn_y = ty_s + C_OFF; end
         default: ;
      endcase
   end

   always_comb begin
      next_x = cur_x;
      next_y = cur_y;
      case (dir_q)
         UP:    next_y = cur_y - SPD;
         RIGHT: next_x = cur_x + SPD;
         DOWN:  next_y = cur_y + SPD;
         LEFT:  next_x = cur_x - SPD;
         default: ;
      endcase
   end

   // One timer serves cooldown and explosion; a state change always restarts it.
   assign tc_enable   = startOfFrame && (state_q != S_IDLE) && (state_q != S_FLYING);
   assign tc_clear    = (state_d != state_q);
   assign tc_terminal = (state_q == S_COOLDOWN) ? CNT_W'(COOLDOWN_FRAMES)
                                                : CNT_W'(EXPLODE_FRAMES);

   frame_counter #(.WIDTH(CNT_W)) u_timer (
      .clk      (clk),
      .reset    (reset),
      .clear    (tc_clear),
      .enable   (tc_enable),
      .terminal (tc_terminal),
      .count    (tc_count),
      .hit      (tc_hit)
   );

   always_comb begin
      state_d   = state_q;
      dir_d     = dir_q;
      x_d       = x_q;
      y_d       = y_q;
      en_d      = en_q;
`ifdef ROCKET_EXPLOSION_EN
      explode_d = explode_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (fire_edge) begin
               if (in_bounds(spawn_x, spawn_y, MAX_X, MAX_Y)) begin
                  x_d     = spawn_x[10:0];
                  y_d     = spawn_y[10:0];
                  dir_d   = dir_t'(tank_direction);
                  en_d    = 1'b1;
                  state_d = S_FLYING;
               end else begin
                  state_d = S_COOLDOWN;
               end
            end
         end
         S_FLYING: begin
            if (collision) begin
`ifdef ROCKET_EXPLOSION_EN
               explode_d = 1'b1;
               state_d   = S_EXPLODE;
`else
               en_d      = 1'b0;
               state_d   = S_COOLDOWN;
`endif
            end else if (startOfFrame) begin
               if (in_bounds(next_x, next_y, MAX_X, MAX_Y)) begin
                  x_d = next_x[10:0];
                  y_d = next_y[10:0];
               end else begin
                  en_d    = 1'b0;
                  state_d = S_COOLDOWN;
               end
            end
         end
         S_COOLDOWN: begin
            if (tc_hit)
               state_d = S_IDLE;
         end
`ifdef ROCKET_EXPLOSION_EN
         S_EXPLODE: begin
            if (tc_hit) begin
               en_d      = 1'b0;
               explode_d = 1'b0;
               state_d   = S_COOLDOWN;
            end
         end
`endif
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         dir_q       <= UP;
         x_q         <= '0;
         y_q         <= '0;
         en_q        <= 1'b0;
         fire_prev_q <= 1'b0;
`ifdef ROCKET_EXPLOSION_EN
         explode_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         dir_q       <= dir_d;
         x_q         <= x_d;
         y_q         <= y_d;
         en_q        <= en_d;
         fire_prev_q <= fire_key;
`ifdef ROCKET_EXPLOSION_EN
         explode_q   <= explode_d;
`endif
      end
   end

   assign topLeftX       = x_q;
   assign topLeftY       = y_q;
   assign last_direction = dir_q;
   assign rocket_enable  = en_q;
`ifdef ROCKET_EXPLOSION_EN
   assign explode        = explode_q;
`else
   assign explode        = 1'b0;
`endif

endmodule

// File: tb/tb_rocket_move.sv
// Directed bench for rocket_move: spawn, flight, exit, collision, cooldown, reset.
module tb_rocket_move;

   logic        clk = 1'b0;
   logic        reset, startOfFrame, fire_key, collision;
   logic [10:0] tank_topLeftX, tank_topLeftY;
   logic [1:0]  tank_direction;
   logic [10:0] topLeftX, topLeftY;
   logic [1:0]  last_direction;
   logic        rocket_enable, explode;

   int n_checks = 0;
   int n_errors = 0;

   rocket_move dut (
      .clk            (clk),
      .reset          (reset),
      .startOfFrame   (startOfFrame),
      .fire_key       (fire_key),
      .tank_topLeftX  (tank_topLeftX),
      .tank_topLeftY  (tank_topLeftY),
      .tank_direction (tank_direction),
      .collision      (collision),
      .topLeftX       (topLeftX),
      .topLeftY       (topLeftY),
      .last_direction (last_direction),
      .rocket_enable  (rocket_enable),
      .explode        (explode)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic frame();
      startOfFrame = 1'b1;
      tick();
      startOfFrame = 1'b0;
      tick();
   endtask

   task automatic set_tank(input int x, input int y, input int d);
      tank_topLeftX  = 11'(x);
      tank_topLeftY  = 11'(y);
      tank_direction = 2'(d);
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_x"},   32'(topLeftX), 0);
      check({tag, "_y"},   32'(topLeftY), 0);
      check({tag, "_dir"}, 32'(last_direction), 0);
      check({tag, "_en"},  32'(rocket_enable), 0);
      check({tag, "_exp"}, 32'(explode), 0);
   endtask

   // Collision retires the rocket with its position frozen.
   task automatic retire_collision(input logic with_sof, input int ex, input int ey);
      collision    = 1'b1;
      startOfFrame = with_sof;
      tick();
      collision    = 1'b0;
      startOfFrame = 1'b0;
      check("col_x", 32'(topLeftX), 32'(ex));
      check("col_y", 32'(topLeftY), 32'(ey));
`ifdef ROCKET_EXPLOSION_EN
      check("col_en",  32'(rocket_enable), 1);
      check("col_exp", 32'(explode), 1);
      repeat (7) frame();
      check("exp7_exp", 32'(explode), 1);
      check("exp7_x",   32'(topLeftX), 32'(ex));
      frame();
      check("exp8_exp", 32'(explode), 0);
      check("exp8_en",  32'(rocket_enable), 0);
`else
      check("col_en",  32'(rocket_enable), 0);
      check("col_exp", 32'(explode), 0);
`endif
   endtask

   // Assumes `pre` cooldown frames already elapsed; ends in IDLE with key released.
   task automatic run_cooldown(input int pre);
      fire_key = 1'b1;
      repeat (29 - pre) frame();
      fire_key = 1'b0;
      tick();
      fire_key = 1'b1;
      tick();
      check("cd_edge29", 32'(rocket_enable), 0);
      frame();
      check("cd_held", 32'(rocket_enable), 0);
      fire_key = 1'b0;
      tick();
   endtask

   initial begin
      reset = 1'b1; startOfFrame = 1'b0; fire_key = 1'b0; collision = 1'b0;
      set_tank(0, 0, 0);
      tick(); tick();
      check_reset_state("rst");
      reset = 1'b0;

      // spawn up and fly three frames
      set_tank(100, 200, 0);
      tick();
      fire_key = 1'b1;
      tick();
      check("up_x",   32'(topLeftX), 112);
      check("up_y",   32'(topLeftY), 192);
      check("up_dir", 32'(last_direction), 0);
      check("up_en",  32'(rocket_enable), 1);
      fire_key = 1'b0;
      repeat (3) frame();
      check("up_y3", 32'(topLeftY), 180);
      check("up_x3", 32'(topLeftX), 112);
      retire_collision(1'b1, 112, 180);
      run_cooldown(0);

      // spawn right; tank turning and moving must not affect the rocket
      set_tank(100, 200, 1);
      fire_key = 1'b1;
      tick();
      check("rt_x",   32'(topLeftX), 132);
      check("rt_y",   32'(topLeftY), 212);
      check("rt_dir", 32'(last_direction), 1);
      check("rt_en",  32'(rocket_enable), 1);
      fire_key = 1'b0;
      set_tank(150, 50, 2);
      frame(); frame();
      check("rt_x2",   32'(topLeftX), 140);
      check("rt_y2",   32'(topLeftY), 212);
      check("rt_dir2", 32'(last_direction), 1);
      retire_collision(1'b0, 140, 212);
      run_cooldown(0);

      // top-edge exit
      set_tank(100, 14, 0);
      fire_key = 1'b1;
      tick();
      check("ex_x", 32'(topLeftX), 112);
      check("ex_y", 32'(topLeftY), 6);
      fire_key = 1'b0;
      frame();
      check("ex_y1",  32'(topLeftY), 2);
      check("ex_en1", 32'(rocket_enable), 1);
      frame();
      check("ex_en", 32'(rocket_enable), 0);
      check("ex_yh", 32'(topLeftY), 2);
      repeat (5) frame();
      fire_key = 1'b1;
      tick();
      check("ex_ign", 32'(rocket_enable), 0);
      run_cooldown(5);

      // blocked spawn above the screen goes straight to cooldown
      set_tank(100, 4, 0);
      fire_key = 1'b1;
      tick();
      check("blk_en", 32'(rocket_enable), 0);
      check("blk_y",  32'(topLeftY), 2);
      fire_key = 1'b0;
      tick();
      set_tank(268, 88, 1);
      run_cooldown(0);

      // reset mid-flight, then fire again immediately
      fire_key = 1'b1;
      tick();
      check("rs_x",  32'(topLeftX), 300);
      check("rs_y",  32'(topLeftY), 100);
      check("rs_en", 32'(rocket_enable), 1);
      fire_key = 1'b0;
      reset = 1'b1;
      tick();
      check_reset_state("mid");
      reset = 1'b0;
      set_tank(268, 88, 3);
      tick();
      fire_key = 1'b1;
      tick();
      check("pr_x",   32'(topLeftX), 260);
      check("pr_y",   32'(topLeftY), 100);
      check("pr_dir", 32'(last_direction), 3);
      check("pr_en",  32'(rocket_enable), 1);
      fire_key = 1'b0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
